// File: rtl/led_group_pkg.sv
// Shared constants and types for the LED group controller.
package led_group_pkg;

    localparam int unsigned NUM_GROUPS = 4;
    localparam int unsigned GROUP_W    = 4;
    localparam int unsigned LED_W      = NUM_GROUPS * GROUP_W;

    localparam int unsigned GRP_L = 3;
    localparam int unsigned GRP_U = 2;
    localparam int unsigned GRP_R = 1;
    localparam int unsigned GRP_D = 0;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Per-button path: 2-FF synchroniser, RELEASED/PRESSED debouncer, and
// rising-edge press pulse.
module btn_debounce
    import led_group_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    btn_state_t       state;
    btn_state_t       state_next;
    btn_state_t       prev_state;
    btn_state_t       synced_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            state      <= RELEASED;
            prev_state <= RELEASED;
            cnt        <= '0;
        end else begin
            sync_q     <= {sync_q[0], btn};
            state      <= state_next;
            prev_state <= state;
            cnt        <= cnt_next;
        end
    end

    assign synced_state = sync_q[1] ? PRESSED : RELEASED;

    // Count consecutive disagreeing samples; the final one flips the state.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        if (synced_state != state) begin
            if (cnt == CNT_MAX) begin
                state_next = synced_state;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    assign level = (state == PRESSED);
    assign press = (state == PRESSED) && (prev_state == RELEASED);

endmodule

// File: rtl/led_group_ctrl.sv
// Debounced per-group LED enables with btnC re-enable-all and registered LEDs.
// Optional blink of disabled groups is enabled by defining LED_GROUP_BLINK_EN.
module led_group_ctrl
    import led_group_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LED_W-1:0]      sw,
    input  logic                  btnL,
    input  logic                  btnU,
    input  logic                  btnR,
    input  logic                  btnD,
    input  logic                  btnC,
    output logic [LED_W-1:0]      led,
    output logic [NUM_GROUPS-1:0] grp_en
);

    logic [NUM_GROUPS-1:0] grp_btn;
    logic [NUM_GROUPS-1:0] grp_press;
    logic [NUM_GROUPS:0]   level_unused;
    logic                  all_press;
    logic [NUM_GROUPS-1:0] show;
    logic [LED_W-1:0]      led_next;

    assign grp_btn[GRP_L] = btnL;
    assign grp_btn[GRP_U] = btnU;
    assign grp_btn[GRP_R] = btnR;
    assign grp_btn[GRP_D] = btnD;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .rst   (rst),
            .btn   (grp_btn[g]),
            .level (level_unused[g]),
            .press (grp_press[g])
        );
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_c (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnC),
        .level (level_unused[NUM_GROUPS]),
        .press (all_press)
    );

    // btnC wins over any simultaneous group toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_en <= '1;
        end else if (all_press) begin
            grp_en <= '1;
        end else begin
            grp_en <= grp_en ^ grp_press;
        end
    end

`ifdef LED_GROUP_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    assign show = grp_en | {NUM_GROUPS{blink_phase}};
`else
    localparam int unsigned BLINK_CYCLES_UNUSED = BLINK_CYCLES;

    assign show = grp_en;
`endif

    always_comb begin
        led_next = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (show[g]) begin
                led_next[g*GROUP_W +: GROUP_W] = sw[g*GROUP_W +: GROUP_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_group_ctrl.sv
// Randomised and directed bench for led_group_ctrl against a sample-window
// reference model of the button/enable/LED behaviour.
module tb_led_group_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned BLK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw = 16'h0;
    logic        btnL = 1'b0, btnU = 1'b0, btnR = 1'b0, btnD = 1'b0, btnC = 1'b0;
    logic [15:0] led;
    logic [3:0]  grp_en;

    int unsigned tests  = 0;
    int unsigned errors = 0;

    // Model state: raw samples delayed two edges, last DEB debounced samples.
    logic [4:0] m_d1, m_d2, m_level, m_prev;
    logic       m_seen [5][DEB];
    logic [3:0] m_grp;
    logic [15:0] m_led;
`ifdef LED_GROUP_BLINK_EN
    int unsigned m_n;
`endif

    led_group_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_CYCLES    (BLK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .btnL   (btnL),
        .btnU   (btnU),
        .btnR   (btnR),
        .btnD   (btnD),
        .btnC   (btnC),
        .led    (led),
        .grp_en (grp_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Button vector order: {C, L, U, R, D}; bit g (g<4) is group g.
    task automatic model_step();
        logic [4:0] press;
        logic [3:0] on;
        logic       all_diff;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_prev = '0;
            for (int b = 0; b < 5; b++)
                for (int i = 0; i < DEB; i++) m_seen[b][i] = 1'b0;
            m_grp = 4'hF;
            m_led = 16'h0;
`ifdef LED_GROUP_BLINK_EN
            m_n = 0;
`endif
        end else begin
            press = m_level & ~m_prev;
            on = m_grp;
`ifdef LED_GROUP_BLINK_EN
            if (((m_n / BLK) % 2) == 1) on = 4'hF;
            m_n++;
`endif
            for (int g = 0; g < 4; g++)
                m_led[g*4 +: 4] = on[g] ? sw[g*4 +: 4] : 4'h0;
            if (press[4]) m_grp = 4'hF;
            else          m_grp = m_grp ^ press[3:0];
            m_prev = m_level;
            // A level is accepted once DEB consecutive samples disagree with it.
            for (int b = 0; b < 5; b++) begin
                for (int i = DEB - 1; i > 0; i--) m_seen[b][i] = m_seen[b][i-1];
                m_seen[b][0] = m_d2[b];
                all_diff = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (m_seen[b][i] == m_level[b]) all_diff = 1'b0;
                if (all_diff) m_level[b] = ~m_level[b];
            end
            m_d2 = m_d1;
            m_d1 = {btnC, btnL, btnU, btnR, btnD};
        end
    endtask

    task automatic step(input logic r, input logic [4:0] b, input logic [15:0] s);
        rst = r;
        {btnC, btnL, btnU, btnR, btnD} = b;
        sw = s;
        @(posedge clk);
        model_step();
        #1;
        check("led", led, m_led);
        check("grp_en", {12'h0, grp_en}, {12'h0, m_grp});
    endtask

    task automatic idle(input int n, input logic [15:0] s);
        for (int i = 0; i < n; i++) step(1'b0, 5'b00000, s);
    endtask

    task automatic hold(input int n, input logic [4:0] b, input logic [15:0] s);
        for (int i = 0; i < n; i++) step(1'b0, b, s);
    endtask

    initial begin
        logic [4:0]  rb;
        logic [15:0] rs;
        int          len;

        // Reset, then mid-run reset with A5C3.
        for (int i = 0; i < 3; i++) step(1'b1, 5'b00000, 16'hA5C3);
        idle(5, 16'h1111);
        for (int i = 0; i < 2; i++) step(1'b1, 5'b00000, 16'hA5C3);
        check("rst_led", led, 16'h0000);
        check("rst_grp", {12'h0, grp_en}, 16'h000F);
        step(1'b0, 5'b00000, 16'hA5C3);
        check("rst_release_led", led, 16'hA5C3);

        // Toggle group 3 twice.
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 5'b01000, 16'hFFFF);
            if (i == 6) check("l_pre", {12'h0, grp_en}, 16'h000F);
            if (i == 7) check("l_toggle", {12'h0, grp_en}, 16'h0007);
            if (i == 8) check("l_led", led, 16'h0FFF);
        end
        idle(8, 16'hFFFF);
        hold(10, 5'b01000, 16'hFFFF);
        idle(8, 16'hFFFF);
        check("l_twice", led, 16'hFFFF);

        // Bounce rejection, then a real hold.
        hold(3, 5'b00100, 16'hFFFF);
        hold(1, 5'b00000, 16'hFFFF);
        hold(3, 5'b00100, 16'hFFFF);
        idle(8, 16'hFFFF);
        check("bounce", {12'h0, grp_en}, 16'h000F);
        hold(6, 5'b00100, 16'hFFFF);
        idle(8, 16'hFFFF);
        check("u_hold", {12'h0, grp_en}, 16'h000B);

        // Re-enable, then simultaneous R+D.
        hold(6, 5'b10000, 16'hFFFF);
        idle(8, 16'hFFFF);
        check("c_all", {12'h0, grp_en}, 16'h000F);
        hold(6, 5'b00011, 16'hFFFF);
        idle(8, 16'hFFFF);
        check("rd_led", led, 16'hFF00);

        // btnC beats a same-cycle btnL.
        hold(6, 5'b10000, 16'hFFFF);
        idle(8, 16'hFFFF);
        hold(6, 5'b01010, 16'hFFFF);
        idle(8, 16'h1234);
        check("lr_grp", {12'h0, grp_en}, 16'h0005);
        hold(6, 5'b11000, 16'h1234);
        idle(8, 16'h1234);
        check("c_prio_grp", {12'h0, grp_en}, 16'h000F);
        check("c_prio_led", led, 16'h1234);

        // Reset during a btnD hold forces a full re-debounce.
        hold(2, 5'b00001, 16'hFFFF);
        for (int i = 0; i < 2; i++) step(1'b1, 5'b00001, 16'hFFFF);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 5'b00001, 16'hFFFF);
            if (i == 6) check("d_redeb_pre", {12'h0, grp_en}, 16'h000F);
            if (i == 7) check("d_redeb", {12'h0, grp_en}, 16'h000E);
        end
        idle(8, 16'hFFFF);

        // Group 0 disabled with sw=000F: blink (if built) or steady off.
        idle(40, 16'h000F);

        // Random button segments, switches and occasional reset.
        for (int seg = 0; seg < 400; seg++) begin
            rb  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0) rb = 5'b00000;
            rs  = 16'($urandom);
            len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < len % 3 + 1; i++) step(1'b1, rb, rs);
            end else begin
                hold(len, rb, rs);
            end
        end
        idle(10, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
